hd44780_refresh_sequencer: RTL and testbench

//   Sequences the HD44780 character LCD: runs the power-up init command list once, then on each

---
 rtl/hd44780_refresh_sequencer_if.sv | 22 ++
 rtl/hd44780_refresh_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_hd44780_refresh_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hd44780_refresh_sequencer_if.sv
// Byte-level bus between the refresh sequencer and the HD44780 bus writer.
// The sequencer offers one byte at a time with valid; the writer takes it with ready.
interface hd44780_refresh_sequencer_if;
   logic       lcdValid;
   logic       lcdRs;
   logic [7:0] lcdData;
   logic       lcdReady;

   modport master (
      output lcdValid,
      output lcdRs,
      output lcdData,
      input  lcdReady
   );

   modport slave (
      input  lcdValid,
      input  lcdRs,
      input  lcdData,
      output lcdReady
   );
endinterface

// File: rtl/hd44780_refresh_sequencer.sv
// HD44780 refresh sequencer: runs the power-up init command list once, then on
// each refresh request streams a 2x16 frame (two DDRAM address commands plus
// 32 characters) to the byte-level LCD writer.
module hd44780_refresh_sequencer #(
   parameter int PWRUP_CYCLES = 2_000_000,
   parameter int CLEAR_CYCLES = 100_000
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_update_pulse,
   output logic                          o_update_ack,
   output logic [4:0]                    o_char_addr,
   input  logic [7:0]                    i_char_data,
   hd44780_refresh_sequencer_if.master   lcd,
   output logic                          o_init_done,
   output logic                          o_busy
);

   localparam int MAX_CYCLES   = (PWRUP_CYCLES > CLEAR_CYCLES) ? PWRUP_CYCLES : CLEAR_CYCLES;
   localparam int CNT_W        = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
   localparam int PWRUP_LAST_I = (PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0;
   localparam int CLEAR_LAST_I = (CLEAR_CYCLES > 0) ? CLEAR_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_LAST_I);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_LAST_I);

   typedef enum logic [2:0] {
      PWRUP,
      INIT,
      CLRWAIT,
      IDLE,
      ADDR,
      FETCH,
      SEND
   } state_t;

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [1:0]       cmdIdx_q,   cmdIdx_d;
   logic [4:0]       idx_q,      idx_d;
   logic             valid_q,    valid_d;
   logic             rs_q,       rs_d;
   logic [7:0]       data_q,     data_d;
   logic             ack_q,      ack_d;
   logic             initDone_q, initDone_d;
   logic             xfer;

   // Init command list: 8-bit 2-line mode, display on, entry increment, clear.
   function automatic logic [7:0] initCmd(input logic [1:0] n);
      case (n)
         2'd0:    initCmd = 8'h38;
         2'd1:    initCmd = 8'h0C;
         2'd2:    initCmd = 8'h06;
         default: initCmd = 8'h01;
      endcase
   endfunction

   assign xfer = valid_q & lcd.lcdReady;

   // State and datapath registers; reset drops everything back to the power-up wait.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= PWRUP;
         cnt_q      <= '0;
         cmdIdx_q   <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         rs_q       <= 1'b0;
         data_q     <= 8'h00;
         ack_q      <= 1'b0;
         initDone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmdIdx_q   <= cmdIdx_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         rs_q       <= rs_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         initDone_q <= initDone_d;
      end
   end

   // Next-state logic; each byte-sending state raises valid once and drops it right after its transfer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmdIdx_d   = cmdIdx_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      rs_d       = rs_q;
      data_d     = data_q;
      ack_d      = 1'b0;
      initDone_d = initDone_q;

      case (state_q)
         PWRUP: begin
            if ((PWRUP_CYCLES == 0) || (cnt_q == PWRUP_LAST)) begin
               state_d  = INIT;
               cnt_d    = '0;
               cmdIdx_d = 2'd0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         INIT: begin
            if (xfer) begin
               valid_d = 1'b0;
               if (cmdIdx_q == 2'd3) begin
                  cnt_d = '0;
                  if (CLEAR_CYCLES == 0) begin
                     initDone_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     state_d = CLRWAIT;
                  end
               end else begin
                  cmdIdx_d = cmdIdx_q + 2'd1;
               end
            end else if (!valid_q) begin
               valid_d = 1'b1;
               rs_d    = 1'b0;
               data_d  = initCmd(cmdIdx_q);
            end
         end

         CLRWAIT: begin
            if (cnt_q == CLEAR_LAST) begin
               cnt_d      = '0;
               initDone_d = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         IDLE: begin
            if (i_update_pulse) begin
               ack_d   = 1'b1;
               idx_d   = 5'd0;
               state_d = ADDR;
            end
         end

         ADDR: begin
            if (xfer) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end else if (!valid_q) begin
               valid_d = 1'b1;
               rs_d    = 1'b0;
               data_d  = idx_q[4] ? 8'hC0 : 8'h80;
            end
         end

         FETCH: begin
            state_d = SEND;
         end

         SEND: begin
            if (xfer) begin
               valid_d = 1'b0;
               if (idx_q == 5'd31) begin
                  state_d = IDLE;
               end else if (idx_q == 5'd15) begin
                  idx_d   = 5'd16;
                  state_d = ADDR;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = FETCH;
               end
            end else if (!valid_q) begin
               valid_d = 1'b1;
               rs_d    = 1'b1;
               data_d  = i_char_data;
            end
         end

         default: begin
            state_d = PWRUP;
         end
      endcase
   end

   assign lcd.lcdValid = valid_q;
   assign lcd.lcdRs    = rs_q;
   assign lcd.lcdData  = data_q;
   assign o_update_ack = ack_q;
   assign o_char_addr  = idx_q;
   assign o_init_done  = initDone_q;
   assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hd44780_refresh_sequencer.sv
// Testbench for hd44780_refresh_sequencer: records every bus transfer and compares
// it with the byte stream the LCD should receive (init list, then 80/line1/C0/line2).
module tb_hd44780_refresh_sequencer;

   localparam int PWRUP = 10;
   localparam int CLEAR = 5;

   logic       clk;
   logic       rst;
   logic       updatePulse;
   logic       updateAck;
   logic [4:0] charAddr;
   logic [7:0] charData;
   logic       initDone;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [7:0] frameBuf [32];
   logic [8:0] xferQ [$];
   int         xferEdgeQ [$];
   int         ackEdgeQ [$];
   logic [8:0] expQ [$];
   logic [8:0] initExp [4];

   hd44780_refresh_sequencer_if lcdIf();

   hd44780_refresh_sequencer #(
      .PWRUP_CYCLES (PWRUP),
      .CLEAR_CYCLES (CLEAR)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_update_pulse (updatePulse),
      .o_update_ack   (updateAck),
      .o_char_addr    (charAddr),
      .i_char_data    (charData),
      .lcd            (lcdIf.master),
      .o_init_done    (initDone),
      .o_busy         (busy)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to timestamp transfers and acks.
   always @(posedge clk) cyc <= cyc + 1;

   // Display buffer model: data follows the address one cycle later.
   always @(posedge clk) charData <= frameBuf[charAddr];

   // Bus monitor: logs each accepted byte and each ack cycle.
   always @(posedge clk) begin
      if (lcdIf.lcdValid && lcdIf.lcdReady) begin
         xferQ.push_back({lcdIf.lcdRs, lcdIf.lcdData});
         xferEdgeQ.push_back(cyc);
      end
      if (updateAck) ackEdgeQ.push_back(cyc);
   end

   task automatic clearLogs();
      xferQ.delete();
      xferEdgeQ.delete();
      ackEdgeQ.delete();
      expQ.delete();
   endtask

   task automatic appendInit();
      for (int i = 0; i < 4; i++) expQ.push_back(initExp[i]);
   endtask

   // Reference frame: line 1 address, 16 chars, line 2 address, 16 chars.
   task automatic appendFrame();
      expQ.push_back({1'b0, 8'h80});
      for (int i = 0; i < 16; i++) expQ.push_back({1'b1, frameBuf[i]});
      expQ.push_back({1'b0, 8'hC0});
      for (int i = 16; i < 32; i++) expQ.push_back({1'b1, frameBuf[i]});
   endtask

   task automatic randomBuffer();
      for (int i = 0; i < 32; i++) frameBuf[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic waitXfers(input int n, input int bound);
      for (int k = 0; k < bound && xferQ.size() < n; k++) @(negedge clk);
   endtask

   // Raise a request, hold it until acked, then release it.
   task automatic requestFrame(output bit gotAck);
      gotAck = 1'b0;
      @(negedge clk);
      updatePulse = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (updateAck) begin
            gotAck = 1'b1;
            break;
         end
      end
      updatePulse = 1'b0;
   endtask

   // Wait for init to finish so a test starts from IDLE.
   task automatic waitInitDone();
      for (int k = 0; k < 300 && !initDone; k++) @(negedge clk);
   endtask

   task automatic test_reset();
      updatePulse      = 1'b0;
      lcdIf.lcdReady   = 1'b1;
      rst              = 1'b0;
      for (int i = 0; i < 32; i++) frameBuf[i] = 8'h00;
      #2 rst = 1'b1;
      #1;
      checks++; if (lcdIf.lcdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", lcdIf.lcdValid); end
      checks++; if (lcdIf.lcdRs !== 1'b0) begin errors++; $display("[TB] FAIL reset_rs: got %b want 0", lcdIf.lcdRs); end
      checks++; if (lcdIf.lcdData !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h want 00", lcdIf.lcdData); end
      checks++; if (updateAck !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b want 0", updateAck); end
      checks++; if (charAddr !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", charAddr); end
      checks++; if (initDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %b want 0", initDone); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_init();
      bit quiet = 1'b1;
      int doneEdge = -1;
      clearLogs();
      appendInit();
      rst = 1'b0;
      repeat (PWRUP) begin
         @(negedge clk);
         if (lcdIf.lcdValid !== 1'b0) quiet = 1'b0;
      end
      checks++; if (!quiet) begin errors++; $display("[TB] FAIL pwrup_quiet: got valid during wait want none"); end
      waitXfers(4, 100);
      checks++; if (xferQ.size() != 4) begin errors++; $display("[TB] FAIL init_count: got %0d want 4", xferQ.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= xferQ.size() || xferQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL init_byte%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : 9'h1FF, expQ[i]);
         end
      end
      checks++; if (busy !== 1'b1 || initDone !== 1'b0) begin errors++; $display("[TB] FAIL clrwait_flags: got busy=%b done=%b want 1/0", busy, initDone); end
      for (int k = 0; k < 100; k++) begin
         if (initDone === 1'b1) begin
            doneEdge = cyc - 1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (xferEdgeQ.size() < 4 || doneEdge < 0 || doneEdge - xferEdgeQ[3] != CLEAR) begin
         errors++;
         $display("[TB] FAIL init_done_delay: got %0d want %0d", (xferEdgeQ.size() >= 4 && doneEdge >= 0) ? doneEdge - xferEdgeQ[3] : -1, CLEAR);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_init: got %b want 0", busy); end
   endtask

   task automatic test_frame();
      bit got;
      for (int i = 0; i < 32; i++) frameBuf[i] = 8'h41 + 8'(i);
      clearLogs();
      appendFrame();
      requestFrame(got);
      checks++; if (!got) begin errors++; $display("[TB] FAIL frame_ack: got no ack want ack"); end
      @(negedge clk);
      checks++; if (updateAck !== 1'b0) begin errors++; $display("[TB] FAIL ack_width: got %b want 0", updateAck); end
      waitXfers(34, 500);
      for (int i = 0; i < 34; i++) begin
         checks++;
         if (i >= xferQ.size() || xferQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL frame_byte%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : 9'h1FF, expQ[i]);
         end
      end
      repeat (20) @(negedge clk);
      checks++; if (xferQ.size() != 34) begin errors++; $display("[TB] FAIL frame_total: got %0d want 34", xferQ.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL frame_idle: got busy=%b want 0", busy); end
      checks++; if (ackEdgeQ.size() != 1) begin errors++; $display("[TB] FAIL frame_acks: got %0d want 1", ackEdgeQ.size()); end
   endtask

   task automatic test_stall();
      bit got;
      bit held = 1'b1;
      logic [8:0] heldByte;
      randomBuffer();
      clearLogs();
      appendFrame();
      requestFrame(got);
      checks++; if (!got) begin errors++; $display("[TB] FAIL stall_ack: got no ack want ack"); end
      for (int k = 0; k < 200 && !(xferQ.size() == 3 && lcdIf.lcdValid); k++) @(negedge clk);
      lcdIf.lcdReady = 1'b0;
      heldByte = {lcdIf.lcdRs, lcdIf.lcdData};
      repeat (7) begin
         @(negedge clk);
         if (lcdIf.lcdValid !== 1'b1 || {lcdIf.lcdRs, lcdIf.lcdData} !== heldByte || xferQ.size() != 3) held = 1'b0;
      end
      checks++; if (!held) begin errors++; $display("[TB] FAIL stall_hold: got changed bus want %h held", heldByte); end
      checks++; if (heldByte !== expQ[3]) begin errors++; $display("[TB] FAIL stall_byte: got %h want %h", heldByte, expQ[3]); end
      lcdIf.lcdReady = 1'b1;
      waitXfers(34, 500);
      repeat (10) @(negedge clk);
      checks++; if (xferQ.size() != 34) begin errors++; $display("[TB] FAIL stall_total: got %0d want 34", xferQ.size()); end
      for (int i = 0; i < 34; i++) begin
         checks++;
         if (i >= xferQ.size() || xferQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL stall_byte%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : 9'h1FF, expQ[i]);
         end
      end
   endtask

   task automatic test_random_ready();
      bit got;
      bit stable = 1'b1;
      bit prevStalled = 1'b0;
      logic [8:0] prevByte = '0;
      randomBuffer();
      clearLogs();
      appendFrame();
      requestFrame(got);
      checks++; if (!got) begin errors++; $display("[TB] FAIL rnd_ack: got no ack want ack"); end
      for (int k = 0; k < 3000 && xferQ.size() < 34; k++) begin
         if (prevStalled && (lcdIf.lcdValid !== 1'b1 || {lcdIf.lcdRs, lcdIf.lcdData} !== prevByte)) stable = 1'b0;
         lcdIf.lcdReady = 1'($urandom_range(0, 1));
         prevStalled = lcdIf.lcdValid && !lcdIf.lcdReady;
         prevByte = {lcdIf.lcdRs, lcdIf.lcdData};
         @(negedge clk);
      end
      lcdIf.lcdReady = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (!stable) begin errors++; $display("[TB] FAIL rnd_stable: got bus change while stalled want held"); end
      checks++; if (xferQ.size() != 34) begin errors++; $display("[TB] FAIL rnd_total: got %0d want 34", xferQ.size()); end
      for (int i = 0; i < 34; i++) begin
         checks++;
         if (i >= xferQ.size() || xferQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL rnd_byte%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : 9'h1FF, expQ[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit got;
      bit got2 = 1'b0;
      randomBuffer();
      clearLogs();
      appendFrame();
      appendFrame();
      requestFrame(got);
      waitXfers(10, 300);
      updatePulse = 1'b1;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (updateAck) begin
            got2 = 1'b1;
            break;
         end
      end
      updatePulse = 1'b0;
      checks++; if (!got || !got2) begin errors++; $display("[TB] FAIL b2b_acks_seen: got %0d want 2", int'(got) + int'(got2)); end
      waitXfers(68, 800);
      repeat (20) @(negedge clk);
      checks++; if (xferQ.size() != 68) begin errors++; $display("[TB] FAIL b2b_total: got %0d want 68", xferQ.size()); end
      checks++; if (ackEdgeQ.size() != 2) begin errors++; $display("[TB] FAIL b2b_ack_count: got %0d want 2", ackEdgeQ.size()); end
      checks++;
      if (ackEdgeQ.size() < 2 || xferEdgeQ.size() < 34 || ackEdgeQ[1] <= xferEdgeQ[33]) begin
         errors++;
         $display("[TB] FAIL b2b_ack_order: got ack before first frame end want after");
      end
      for (int i = 0; i < 68; i++) begin
         checks++;
         if (i >= xferQ.size() || xferQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL b2b_byte%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : 9'h1FF, expQ[i]);
         end
      end
   endtask

   task automatic test_req_during_init();
      bit got = 1'b0;
      randomBuffer();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clearLogs();
      appendInit();
      appendFrame();
      updatePulse = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (updateAck) begin
            got = 1'b1;
            break;
         end
      end
      checks++; if (!got) begin errors++; $display("[TB] FAIL early_ack: got no ack want ack"); end
      checks++; if (initDone !== 1'b1) begin errors++; $display("[TB] FAIL early_ack_done: got %b want 1", initDone); end
      checks++; if (xferQ.size() != 4) begin errors++; $display("[TB] FAIL early_ack_pos: got %0d bytes want 4", xferQ.size()); end
      updatePulse = 1'b0;
      waitXfers(38, 500);
      repeat (20) @(negedge clk);
      checks++; if (xferQ.size() != 38) begin errors++; $display("[TB] FAIL early_total: got %0d want 38", xferQ.size()); end
      for (int i = 0; i < 38; i++) begin
         checks++;
         if (i >= xferQ.size() || xferQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL early_byte%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : 9'h1FF, expQ[i]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      bit got;
      bit quiet = 1'b1;
      randomBuffer();
      clearLogs();
      requestFrame(got);
      for (int k = 0; k < 300 && !(xferQ.size() >= 22 && lcdIf.lcdValid); k++) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (lcdIf.lcdValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b want 0", lcdIf.lcdValid); end
      checks++; if (busy !== 1'b1 || initDone !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags: got busy=%b done=%b want 1/0", busy, initDone); end
      checks++; if (charAddr !== 5'd0) begin errors++; $display("[TB] FAIL midrst_addr: got %0d want 0", charAddr); end
      @(negedge clk);
      @(negedge clk);
      clearLogs();
      appendInit();
      rst = 1'b0;
      repeat (PWRUP) begin
         @(negedge clk);
         if (lcdIf.lcdValid !== 1'b0) quiet = 1'b0;
      end
      checks++; if (!quiet) begin errors++; $display("[TB] FAIL midrst_quiet: got valid during wait want none"); end
      waitXfers(4, 100);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= xferQ.size() || xferQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL midrst_init%0d: got %h want %h", i, (i < xferQ.size()) ? xferQ[i] : 9'h1FF, expQ[i]);
         end
      end
      waitInitDone();
      repeat (5) @(negedge clk);
      checks++; if (xferQ.size() != 4 || initDone !== 1'b1) begin errors++; $display("[TB] FAIL midrst_settle: got %0d bytes done=%b want 4/1", xferQ.size(), initDone); end
   endtask

   // Scenario sequence.
   initial begin
      initExp[0] = 9'h038;
      initExp[1] = 9'h00C;
      initExp[2] = 9'h006;
      initExp[3] = 9'h001;
      test_reset();
      test_init();
      test_frame();
      test_stall();
      test_random_ready();
      test_back_to_back();
      test_req_during_init();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
